// File: rtl/wptr_full.sv
// Write-side pointer and full-flag generator for the async FIFO (write clock domain).
// Optional almost-full flag compiled in with macro WPTR_ALMOST_FULL_EN.

module bin2gray #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

module wptr_full #(
    parameter int ADDR_WIDTH = 5,
    parameter int AF_THRESH  = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  wovf
`ifdef WPTR_ALMOST_FULL_EN
   ,output logic                  walmost_full
`endif
);
    localparam int PW = ADDR_WIDTH + 1;

    // The full test inverts the two top Gray bits, so at least 2 address bits are needed.
    if (ADDR_WIDTH < 2 || AF_THRESH < 0 || AF_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
        $error("wptr_full: unsupported ADDR_WIDTH/AF_THRESH");
    end

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic          wfull_q, wfull_d;
    logic          wovf_q, wovf_d;
    logic          wen;

    assign wen    = winc & ~wfull_q;
    assign wbin_d = wbin_q + PW'(wen);

    bin2gray #(.WIDTH(PW)) u_b2g (
        .bin  (wbin_d),
        .gray (wptr_d)
    );

    // Full when the next write pointer is one lap ahead of the synchronized read pointer.
    assign wfull_d = (wptr_d == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]});
    assign wovf_d  = wovf_q | (winc & wfull_q);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            wovf_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            wfull_q <= wfull_d;
            wovf_q  <= wovf_d;
        end
    end

    assign waddr = wbin_q[ADDR_WIDTH-1:0];
    assign wptr  = wptr_q;
    assign wfull = wfull_q;
    assign wovf  = wovf_q;

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [PW-1:0] AF_LEVEL = PW'((1 << ADDR_WIDTH) - AF_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] used_d;
    logic          walmost_full_q, walmost_full_d;

    always_comb begin
        rbin             = '0;
        rbin[ADDR_WIDTH] = wq2_rptr[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    assign used_d         = wbin_d - rbin;
    assign walmost_full_d = (used_d >= AF_LEVEL);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) walmost_full_q <= 1'b0;
        else         walmost_full_q <= walmost_full_d;
    end

    assign walmost_full = walmost_full_q;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Scoreboard bench for wptr_full: a count-based FIFO occupancy model predicts each edge's outputs.
module tb_wptr_full;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;
    localparam int MOD   = 2 * DEPTH;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          winc;
    logic [AW:0]   wq2_rptr;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          wovf;
    logic          walmost_full;

    wptr_full #(.ADDR_WIDTH(AW), .AF_THRESH(2)) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .wovf     (wovf)
`ifdef WPTR_ALMOST_FULL_EN
       ,.walmost_full (walmost_full)
`endif
    );
`ifndef WPTR_ALMOST_FULL_EN
    assign walmost_full = 1'b0;
`endif

    always #5 wclk = ~wclk;

    typedef struct {
        logic [AW:0]   wptr;
        logic [AW-1:0] waddr;
        logic          full;
        logic          ovf;
        logic          af;
        logic          wrote;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: counts of items written/read, kept as plain integers mod 2*DEPTH.
    int m_bin, r_bin, d1, d2;
    bit m_full, m_ovf, track;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = AW'(0) + (AW+1)'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bin = 0; r_bin = 0; d1 = 0; d2 = 0; m_full = 0; m_ovf = 0;
    endtask

    // Drive one cycle at the falling edge and push what the next rising edge must produce.
    task automatic step(input bit inc, input bit rnd_rd);
        exp_t e;
        int   nb, used;
        bit   wen;
        @(negedge wclk);
        if (track) begin
            r_bin = d2; d2 = d1; d1 = m_bin;
        end else if (rnd_rd && r_bin != m_bin && $urandom_range(0, 1) == 1) begin
            r_bin = (r_bin + 1) % MOD;
        end
        winc     = inc;
        wq2_rptr = gray(r_bin);
        wen      = inc && !m_full;
        nb       = (m_bin + int'(wen)) % MOD;
        used     = (nb - r_bin + MOD) % MOD;
        m_ovf    = m_ovf || (inc && m_full);
        m_full   = (used == DEPTH);
        m_bin    = nb;
        e.wptr   = gray(nb);
        e.waddr  = AW'(nb % DEPTH);
        e.full   = m_full;
        e.ovf    = m_ovf;
        e.af     = (used >= DEPTH - 2);
        e.wrote  = wen;
        sbq.push_back(e);
    endtask

    task automatic async_reset(input string tag);
        @(negedge wclk);
        winc = 1'b0;
        #2 wrst_n = 1'b0;
        #1;
        chk({tag, "_wptr"},  int'(wptr),  0);
        chk({tag, "_waddr"}, int'(waddr), 0);
        chk({tag, "_wfull"}, int'(wfull), 0);
        chk({tag, "_wovf"},  int'(wovf),  0);
`ifdef WPTR_ALMOST_FULL_EN
        chk({tag, "_waf"},   int'(walmost_full), 0);
`endif
        model_reset();
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per rising edge while any are pending.
    logic [AW:0] prev_wptr = '0;
    initial begin
        exp_t e;
        forever begin
            @(posedge wclk);
            #1;
            if (!wrst_n) prev_wptr = '0;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("wptr",  int'(wptr),  int'(e.wptr));
                chk("waddr", int'(waddr), int'(e.waddr));
                chk("wfull", int'(wfull), int'(e.full));
                chk("wovf",  int'(wovf),  int'(e.ovf));
`ifdef WPTR_ALMOST_FULL_EN
                chk("walmost_full", int'(walmost_full), int'(e.af));
`endif
                if (e.wrote) chk("gray_onebit", $countones(prev_wptr ^ wptr), 1);
                prev_wptr = wptr;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        track = 0;
        model_reset();
        winc = 1'b0; wq2_rptr = '0; wrst_n = 1'b0;
        #3;
        chk("rst_wptr",  int'(wptr),  0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_wfull", int'(wfull), 0);
        chk("rst_wovf",  int'(wovf),  0);
        @(negedge wclk);
        wrst_n = 1'b1;

        // Ten writes, then an asynchronous reset between edges.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        async_reset("midrst");

        // Fill with the reader parked at 0, then push once more while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
        @(negedge wclk); #1;
        chk("fill_wptr",  int'(wptr),  int'(6'b110000));
        chk("fill_waddr", int'(waddr), 0);
        chk("fill_wfull", int'(wfull), 1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        @(negedge wclk); #1;
        chk("ovf_wptr",  int'(wptr),  int'(6'b110000));
        chk("ovf_waddr", int'(waddr), 0);
        chk("ovf_sticky", int'(wovf), 1);

        // Release one slot, then refill it.
        r_bin = 1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        @(negedge wclk); #1;
        chk("refill_wptr",  int'(wptr),  int'(6'b110001));
        chk("refill_wfull", int'(wfull), 1);

        // Wrap with the read pointer trailing the write pointer by two cycles.
        async_reset("prewrap");
        track = 1;
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0);
        track = 0;
        @(negedge wclk); #1;
        chk("wrap_wptr", int'(wptr), int'(gray(70 % MOD)));

        // Random writes against a randomly advancing reader.
        async_reset("prerand");
        for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
        repeat (2) @(negedge wclk);
        chk("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
